// File: rtl/seq_gen_pkg.sv
// Shared types for the Moore serial pattern generator.
// MOORE_SEQ_GEN_GAP_EN adds the GAP state between repetitions.
package seq_gen_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int LEN_W_DEF = $clog2(PAT_W_DEF + 1);
  localparam int REP_W_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
`ifdef MOORE_SEQ_GEN_GAP_EN
    S_GAP   = 2'b10,
`endif
    S_DONE  = 2'b11
  } seq_gen_state_t;

endpackage

// File: rtl/moore_seq_gen_if.sv
// Request/serial-output bundle of moore_seq_gen.
// rpt carries the repeat count (repeat is a reserved word).
interface moore_seq_gen_if
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int REP_W = REP_W_DEF
);

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] rpt;
  logic             z;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, len, rpt,
    input  z, valid, busy, done
  );

  modport slave (
    input  start, pattern, len, rpt,
    output z, valid, busy, done
  );

endinterface

// File: rtl/seq_gen_shifter.sv
// Pattern shift register with bit counter for moore_seq_gen.
// load latches a new pattern, reload restarts it, shift advances.
module seq_gen_shifter
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             reload_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             msb_o,
  output logic             last_o
);

  logic [PAT_W-1:0] sreg_q, sreg_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_c;

  always_comb begin
    len_c = (len_i > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len_i;
    sreg_d = sreg_q;
    pat_d  = pat_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    unique case (1'b1)
      load_i: begin
        sreg_d = pattern_i;
        pat_d  = pattern_i;
        len_d  = len_c;
        cnt_d  = len_c;
      end
      reload_i: begin
        sreg_d = pat_q;
        cnt_d  = len_q;
      end
      shift_i: begin
        sreg_d = {sreg_q[PAT_W-2:0], 1'b0};
        cnt_d  = cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
      pat_q  <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
    end
  end

  assign msb_o  = sreg_q[PAT_W-1];
  assign last_o = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/moore_seq_gen.sv
// Moore serial pattern generator: MSB-first bursts with repeats.
// MOORE_SEQ_GEN_GAP_EN inserts one idle cycle between repetitions.
module moore_seq_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int REP_W = REP_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  moore_seq_gen_if.slave  bus
);

  seq_gen_state_t   state_q, state_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             valid_q, busy_q, done_q;
  logic             busy_d;
  logic             in_shift, load, reload, shift;
  logic             msb, last;

  seq_gen_shifter #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .shift_i   (shift),
    .reload_i  (reload),
    .pattern_i (bus.pattern),
    .len_i     (bus.len),
    .msb_o     (msb),
    .last_o    (last)
  );

  always_comb begin
    in_shift = (state_q == S_SHIFT);
    load     = (state_q == S_IDLE) && bus.start && (bus.len != '0);
    reload   = in_shift && last && (rep_q != '0);
    shift    = in_shift && !reload;
    state_d  = state_q;
    rep_d    = rep_q;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_SHIFT;
          rep_d   = bus.rpt;
        end
      end
      S_SHIFT: begin
        if (last) begin
          if (rep_q == '0) begin
            state_d = S_DONE;
          end else begin
            rep_d = rep_q - 1'b1;
`ifdef MOORE_SEQ_GEN_GAP_EN
            state_d = S_GAP;
`endif
          end
        end
      end
`ifdef MOORE_SEQ_GEN_GAP_EN
      S_GAP:   state_d = S_SHIFT;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // Output flags are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rep_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      valid_q <= (state_d == S_SHIFT);
      busy_q  <= busy_d;
      done_q  <= (state_d == S_DONE);
    end
  end

  assign bus.z     = valid_q & msb;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_moore_seq_gen.sv
// Self-checking bench for moore_seq_gen: vector table, corner
// sequences and random bursts against a per-cycle reference model.
module tb_moore_seq_gen;

  localparam int PW = 8;
  localparam int LW = $clog2(PW + 1);
  localparam int RW = 4;
`ifdef MOORE_SEQ_GEN_GAP_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  moore_seq_gen_if #(.PAT_W(PW), .LEN_W(LW), .REP_W(RW)) bus ();

  moore_seq_gen #(.PAT_W(PW), .LEN_W(LW), .REP_W(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef logic [3:0] o_t;
  o_t exp_q[$];

  typedef struct {
    logic [PW-1:0] pat;
    int            len;
    int            rpt;
    logic [31:0]   bits;
    int            nbits;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic o_t outs();
    return {bus.z, bus.valid, bus.busy, bus.done};
  endfunction

  // Expected {z,valid,busy,done} per cycle after the sampling edge.
  function automatic void build(input logic [PW-1:0] pat, input int len,
                                input int rpt);
    int n;
    exp_q.delete();
    n = (len > PW) ? PW : len;
    if (n == 0) begin
      repeat (3) exp_q.push_back(4'b0000);
      return;
    end
    for (int r = 0; r <= rpt; r++) begin
      for (int i = 0; i < n; i++)
        exp_q.push_back({pat[PW-1-i], 3'b110});
      if (r < rpt && G == 1) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
  endfunction

  task automatic run(input string nm, input logic [PW-1:0] pat,
                     input int len, input int rpt, input bit hold,
                     output logic [31:0] stream, output int nbits,
                     output int dur);
    o_t o;
    build(pat, len, rpt);
    bus.pattern = pat;
    bus.len     = LW'(len);
    bus.rpt     = RW'(rpt);
    bus.start   = 1'b1;
    stream = '0;
    nbits  = 0;
    dur    = 0;
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      if (!hold) begin
        bus.start   = 1'b0;
        bus.pattern = PW'($urandom);
        bus.len     = LW'($urandom);
        bus.rpt     = RW'($urandom);
      end
      o = outs();
      chk(nm, int'(o), int'(exp_q[c]));
      if (o[2]) begin
        stream = {stream[30:0], o[3]};
        nbits++;
      end
      if (o[0] && dur == 0) dur = c + 1;
    end
  endtask

  vec_t        vt[7];
  logic [31:0] st;
  int          nb, du, lc, edur, dcnt;

  initial begin
    vt[0] = '{8'b1010_0000, 3,  0, 32'b101,       3};
    vt[1] = '{8'b1010_0000, 3,  2, 32'b101101101, 9};
    vt[2] = '{8'b1010_0000, 0,  0, 32'h0,         0};
    vt[3] = '{8'hA5,        15, 0, 32'hA5,        8};
    vt[4] = '{8'hFF,        8,  1, 32'hFFFF,      16};
    vt[5] = '{8'h80,        1,  3, 32'hF,         4};
    vt[6] = '{8'h01,        8,  0, 32'h01,        8};

    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.len     = '0;
    bus.rpt     = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", int'(outs()), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", int'(outs()), 0);

    foreach (vt[i]) begin
      run($sformatf("vec%0d_cycle", i), vt[i].pat, vt[i].len, vt[i].rpt,
          1'b0, st, nb, du);
      lc   = (vt[i].len > PW) ? PW : vt[i].len;
      edur = (lc == 0) ? 0 : (vt[i].rpt + 1) * lc + vt[i].rpt * G + 1;
      chk($sformatf("vec%0d_stream", i), int'(st), int'(vt[i].bits));
      chk($sformatf("vec%0d_nbits", i), nb, vt[i].nbits);
      chk($sformatf("vec%0d_dur", i), du, edur);
    end

    // Reset during the second bit of a 3-bit burst.
    bus.pattern = 8'b1010_0000;
    bus.len     = LW'(3);
    bus.rpt     = '0;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rst_bit0", int'(outs()), 4'b1110);
    @(negedge clk);
    chk("rst_bit1", int'(outs()), 4'b0110);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_outs", int'(outs()), 0);
    dcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done || bus.busy) dcnt++;
    end
    chk("rst_no_done", dcnt, 0);
    run("rst_replay", 8'b1010_0000, 3, 0, 1'b0, st, nb, du);
    chk("rst_replay_stream", int'(st), 5);

    // start held high: back-to-back bursts one DONE and one IDLE apart.
    for (int b = 0; b < 3; b++)
      run("hold_cycle", 8'b1100_0000, 2, 0, 1'b1, st, nb, du);
    bus.start = 1'b0;
    @(negedge clk);
    chk("hold_drain", int'(outs()), 0);

    for (int t = 0; t < 40; t++)
      run("rand_cycle", PW'($urandom), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 3)), 1'b0, st, nb, du);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/moore_seq_gen.md
# moore_seq_gen

Moore-style serial pattern generator. It serialises a parallel bit pattern MSB-first onto a single-bit line, one bit per clock, optionally repeating it. It is the transmit-side counterpart of the team's serial sequence detectors and drives their `x` input in loopback benches and on-chip test paths. A one-cycle `done` pulse marks the end of each burst.

## Interface
Parameters:
- `PAT_W`, default 8: pattern register width; maximum burst length in bits.
- `LEN_W`, default `$clog2(PAT_W+1)`: width of `len`.
- `REP_W`, default 4: width of `repeat`.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a burst; sampled only in IDLE.
- `pattern`, input, PAT_W: bits to send, left-justified; `pattern[PAT_W-1]` goes out first.
- `len`, input, LEN_W: number of bits per repetition.
- `repeat`, input, REP_W: extra repetitions; 0 means the pattern is sent once.
- `z`, output, 1: serial data, registered.
- `valid`, output, 1: high while `z` carries a pattern bit.
- `busy`, output, 1: high while a burst is in progress.
- `done`, output, 1: one-cycle pulse after the last bit.

## Operation
- States: IDLE, SHIFT, GAP (only when the gap feature is compiled in), DONE. Two-bit binary encoding.
- All outputs are Moore outputs, decoded from the state and registers only. No input reaches an output combinationally.
- Outputs by state:
  - IDLE: `z=0`, `valid=0`, `busy=0`, `done=0`.
  - SHIFT: `z=sreg[PAT_W-1]`, `valid=1`, `busy=1`.
  - GAP: `z=0`, `valid=0`, `busy=1`.
  - DONE: `z=0`, `valid=0`, `busy=0`, `done=1`.
- IDLE, when `start=1` and `len!=0`:
  - Latch `pattern` into `pat_q` and `sreg`.
  - Latch `len` into `len_q`; values above PAT_W clamp to PAT_W.
  - Set `bit_cnt=len_q` and `rep_cnt=repeat`.
  - Go to SHIFT.
- IDLE, when `start=1` and `len==0`: ignored. Stay in IDLE and produce no `done`.
- SHIFT, each cycle: `sreg` shifts left by one with zero fill, and `bit_cnt` decrements.
- SHIFT, on the last bit (`bit_cnt==1`):
  - If `rep_cnt==0`: go to DONE.
  - Otherwise: decrement `rep_cnt`, reload `sreg` from `pat_q`, reload `bit_cnt` from `len_q`, then go to GAP (feature on) or stay in SHIFT (feature off). With the feature off, bits stay back-to-back with no bubble.
- GAP: one cycle, then SHIFT.
- DONE: one cycle, then IDLE.
- `start` is ignored in SHIFT, GAP and DONE. A `start` held high through DONE launches a new burst on the first IDLE cycle.
- Inputs `pattern`, `len` and `repeat` may change freely once they have been latched.
- Reset: at any clock edge with `rst=1`, including mid-burst, the block goes to IDLE.
  - All outputs are 0 in the following cycle.
  - `sreg`, `pat_q`, `len_q`, `bit_cnt` and `rep_cnt` clear to 0.
  - No `done` is produced for the aborted burst.
- Counter widths: `bit_cnt` is LEN_W bits and `rep_cnt` is REP_W bits. Neither counter wraps: both are reloaded or stopped before reaching 0−1.

## Timing
- Start latency: `start` sampled at edge k → first bit on `z` with `valid=1` during cycle k+1.
- Bit i of a repetition (0-based) appears in cycle k+1+i.
- Burst duration from the sampling edge to the `done` cycle: `(repeat+1)*len + repeat*G + 1` cycles, where G=1 with the gap feature and G=0 without it.
- `busy` falls in the same cycle that `done` rises.
- Earliest next start: the IDLE cycle after DONE, i.e. one cycle after `done`.

## Configuration
- Macro: `MOORE_SEQ_GEN_GAP_EN`.
- Defined: the GAP state exists, and one idle cycle (`z=0`, `valid=0`) is inserted between repetitions.
- Undefined: the GAP state is absent and repetitions are contiguous.

## Structure
- Package `seq_gen_pkg` holds:
  - the state typedef `seq_gen_state_t`;
  - the state encodings;
  - the default-width localparams.
- Sub-module `seq_gen_shifter` contains `sreg`, `pat_q`, `len_q` and `bit_cnt`. It has `load`, `shift` and `reload` controls and a `last` flag.
- The top level keeps the FSM and `rep_cnt`.

## Test plan
- `pattern=8'b1010_0000`, `len=3`, `repeat=0`, pulse `start` → `z` = 1,0,1 with `valid=1` for 3 cycles, then `done` in cycle 4, then IDLE.
- Same pattern with `repeat=2` → `z` = 101101101 (feature off) or 101·101·101 with `valid=0` in each gap (feature on). `done` after 10 or 12 cycles.
- `len=0`, `start=1` → stays IDLE; `busy`, `valid` and `done` all remain 0.
- `len=15` with PAT_W=8, `pattern=8'hA5` → exactly 8 bits 10100101, then `done`.
- `rst=1` on the 2nd bit of a 3-bit burst → next cycle all outputs 0. Assert that no `done` occurs. A fresh `start` then replays from the first bit.
- `start` held high continuously with `len=2`, `repeat=0` → bursts separated by exactly one DONE cycle and one IDLE cycle. `start` pulses during SHIFT have no effect.
